pu_bias_sched: RTL
==================

// Module: pu_bias_sched
// PURPOSE
//  Sequencer in front of the PU bias-add pipe stage. For one tile it walks the output-channel (OC) groups,
//  4 OCs per group. For each group it fetches one bias beat from the bias stream and holds it stable.
//  It then passes cfg_row_num accumulator rows through the valid/ready handshake to the bias-add stage.
//  A one-entry shadow register prefetches the next group's bias, so group changes cost no bubble.
// PARAMETERS
//  BIAS_WD     16  width of one OC bias (signed)
//  ROW_WD       8  width of row count/index
//  GRP_WD       8  width of OC-group count/index
// PORTS
//  clk              in   1          clock
//  rstn             in   1          asynchronous active-low reset
//  cfg_start_i      in   1          one-cycle start pulse; cfg_* sampled on the same cycle
//  cfg_grp_num_i    in   GRP_WD     number of OC groups in the tile (4 OCs each)
//  cfg_row_num_i    in   ROW_WD     rows per OC group
//  busy_o           out  1          high from the accepted start until done_o
//  done_o           out  1          one-cycle pulse when the tile completes
//  bias_vld_i       in   1          bias beat valid
//  bias_rdy_o       out  1          bias beat ready
//  bias_data_i      in   4*BIAS_WD  {oc0,oc1,oc2,oc3}, oc0 in the MSBs
//  acc_vld_i        in   1          upstream accumulator row valid
//  acc_rdy_o        out  1          upstream accumulator row ready
//  pipe_vld_o       out  1          to the bias-add stage input valid
//  pipe_rdy_i       in   1          from the bias-add stage input ready
//  bias_oc0_o..3_o  out  BIAS_WD    biases of the current group, stable for the whole group
//  row_idx_o        out  ROW_WD     row index of the current group
//  grp_idx_o        out  GRP_WD     current group index
// BEHAVIOUR
//  Reset (async, rstn=0)
//   - state=IDLE; counters, bias_cur, bias_shd and shd_vld cleared.
//   - All outputs 0. An in-flight tile is abandoned; no done_o is issued.
//  FSM states: IDLE, LOAD, RUN, DONE (registered state)
//   - IDLE: bias_rdy_o=0, acc_rdy_o=0, pipe_vld_o=0.
//       cfg_start_i latches cfg; row/grp counters are set to 0.
//       If either cfg value is 0, go to DONE; otherwise go to LOAD.
//       cfg_start_i outside IDLE is ignored.
//   - LOAD: bias_rdy_o=1, acc_rdy_o=0, pipe_vld_o=0.
//       On a bias handshake, bias_cur<=bias_data_i and go to RUN.
//   - RUN: combinational pass-through with zero latency:
//       pipe_vld_o = acc_vld_i; acc_rdy_o = pipe_rdy_i; fire = acc_vld_i & pipe_rdy_i.
//     Counters on fire:
//       - Not the last row: row++.
//       - Last row of the group: row<=0, then
//           - last group -> DONE;
//           - else if shd_vld: bias_cur<=bias_shd, shd_vld<=0, grp++, stay in RUN;
//           - else if a bias handshake occurs this cycle: bias_cur<=bias_data_i, grp++, stay in RUN;
//           - else grp++ and go to LOAD.
//     Prefetch:
//       - bias_rdy_o = ~shd_vld & (grp_idx < grp_num-1).
//       - A handshake that does not coincide with a group end writes bias_shd and sets shd_vld.
//   - DONE: done_o=1 for exactly one cycle, busy_o=0 in that cycle, return to IDLE.
//  Output timing
//   - busy_o is registered: 1 in LOAD and RUN.
//   - bias_oc*_o come from the bias_cur register and change only at a group boundary, after the last-row fire.
//  Boundary conditions
//   - Backpressure (pipe_rdy_i=0) holds the counters; acc_rdy_o=0 propagates back in the same cycle.
//   - Bias beats beyond grp_num are never accepted, because bias_rdy_o=0 during the last group.
//   - Counters never wrap past cfg-1.
// STRUCTURE
//  - Shared PU package: PU_OC_PER_GRP=4, the state encoding localparams, BIAS_WD default.
//  - One sub-module: pu_bias_shadow_buf (one-entry cur/shadow register pair with load/promote control).
//  - Everything else (FSM, counters, handshake muxing) is flat in this module.
// TESTING
//  1. grp=2, row=3, bias beats 0x0001..4 / 0x0005..8, acc/pipe always ready:
//     - 6 fires, rows 0,1,2 per group; bias_oc0_o=1 then 5.
//     - 1 LOAD bubble only before group 0; done_o pulses once.
//  2. Same config with the second beat delayed until the last row of group 0 fires:
//     - beat taken directly into bias_cur, no LOAD cycle, no bubble.
//  3. pipe_rdy_i=0 for 5 cycles mid-group:
//     - acc_rdy_o=0, row_idx_o frozen, bias outputs stable; resumes at the same row.
//  4. cfg_row_num_i=0 (or grp=0):
//     - done_o the cycle after DONE is entered; no bias beat accepted, pipe_vld_o never 1.
//  5. rstn low during RUN of group 1:
//     - all outputs 0 asynchronously; no done_o; a new start with grp=1,row=1 completes normally.
//  6. cfg_start_i pulsed while busy:
//     - ignored; tile finishes with the original cfg.

Source files
------------

// File: rtl/pu_bias_sched_pkg.sv
`default_nettype none
// ============================================================================
// pu_bias_sched_pkg : shared PU constants and bias-sequencer state encoding
// Rev 1.0
// ============================================================================
package pu_bias_sched_pkg;

  localparam int PU_OC_PER_GRP = 4;
  localparam int PU_BIAS_WD    = 16;
  localparam int PU_STATE_WD   = 2;

  typedef enum logic [PU_STATE_WD-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } pu_state_e;

endpackage
`default_nettype wire

// File: rtl/pu_bias_shadow_buf.sv
`default_nettype none
// ============================================================================
// pu_bias_shadow_buf : current bias register plus one-entry prefetch shadow
// Rev 1.0
// ============================================================================
module pu_bias_shadow_buf
  import pu_bias_sched_pkg::*;
#(
  parameter int DATA_WD = PU_OC_PER_GRP * PU_BIAS_WD
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr_i,
  input  logic               load_cur_i,
  input  logic               load_shd_i,
  input  logic               promote_i,
  input  logic [DATA_WD-1:0] data_i,
  output logic [DATA_WD-1:0] cur_o,
  output logic               shd_vld_o
);

  logic [DATA_WD-1:0] cur_q, cur_d;
  logic [DATA_WD-1:0] shd_q, shd_d;
  logic               shd_vld_q, shd_vld_d;

  always_comb begin
    cur_d     = cur_q;
    shd_d     = shd_q;
    shd_vld_d = shd_vld_q;
    if (promote_i) begin
      cur_d     = shd_q;
      shd_vld_d = 1'b0;
    end else if (load_cur_i) begin
      cur_d = data_i;
    end
    if (load_shd_i) begin
      shd_d     = data_i;
      shd_vld_d = 1'b1;
    end
    if (clr_i) begin
      shd_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_q     <= '0;
      shd_q     <= '0;
      shd_vld_q <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      shd_q     <= shd_d;
      shd_vld_q <= shd_vld_d;
    end
  end

  assign cur_o     = cur_q;
  assign shd_vld_o = shd_vld_q;

endmodule
`default_nettype wire

// File: rtl/pu_bias_sched.sv
`default_nettype none
// ============================================================================
// pu_bias_sched : walks OC groups of a tile, holds each group's bias stable
// and passes the group's accumulator rows through to the bias-add stage.
// Rev 1.0
// ============================================================================
module pu_bias_sched
  import pu_bias_sched_pkg::*;
#(
  parameter int BIAS_WD = PU_BIAS_WD,
  parameter int ROW_WD  = 8,
  parameter int GRP_WD  = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       cfg_start_i,
  input  logic [GRP_WD-1:0]          cfg_grp_num_i,
  input  logic [ROW_WD-1:0]          cfg_row_num_i,
  output logic                       busy_o,
  output logic                       done_o,
  input  logic                       bias_vld_i,
  output logic                       bias_rdy_o,
  input  logic [4*BIAS_WD-1:0]       bias_data_i,
  input  logic                       acc_vld_i,
  output logic                       acc_rdy_o,
  output logic                       pipe_vld_o,
  input  logic                       pipe_rdy_i,
  output logic [BIAS_WD-1:0]         bias_oc0_o,
  output logic [BIAS_WD-1:0]         bias_oc1_o,
  output logic [BIAS_WD-1:0]         bias_oc2_o,
  output logic [BIAS_WD-1:0]         bias_oc3_o,
  output logic [ROW_WD-1:0]          row_idx_o,
  output logic [GRP_WD-1:0]          grp_idx_o
);

  localparam int BEAT_WD = PU_OC_PER_GRP * BIAS_WD;

  pu_state_e          state_q, state_d;
  logic [ROW_WD-1:0]  row_q, row_d, row_num_q, row_num_d;
  logic [GRP_WD-1:0]  grp_q, grp_d, grp_num_q, grp_num_d;
  logic               busy_q, busy_d;
  logic [BEAT_WD-1:0] bias_cur;
  logic               shd_vld;
  logic               buf_clr, load_cur, load_shd, promote;
  logic               in_run, fire, bias_hs, last_row, last_grp, pre_ok;

  assign in_run   = (state_q == ST_RUN);
  assign last_row = (row_q == row_num_q - ROW_WD'(1));
  assign last_grp = (grp_q == grp_num_q - GRP_WD'(1));
  // Prefetch only while another group still follows the current one.
  assign pre_ok   = ({1'b0, grp_q} + (GRP_WD+1)'(1)) < {1'b0, grp_num_q};

  assign bias_rdy_o = (state_q == ST_LOAD) | (in_run & ~shd_vld & pre_ok);
  assign pipe_vld_o = in_run & acc_vld_i;
  assign acc_rdy_o  = in_run & pipe_rdy_i;
  assign fire       = in_run & acc_vld_i & pipe_rdy_i;
  assign bias_hs    = bias_vld_i & bias_rdy_o;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    grp_d     = grp_q;
    row_num_d = row_num_q;
    grp_num_d = grp_num_q;
    buf_clr   = 1'b0;
    load_cur  = 1'b0;
    load_shd  = 1'b0;
    promote   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start_i) begin
          row_num_d = cfg_row_num_i;
          grp_num_d = cfg_grp_num_i;
          row_d     = '0;
          grp_d     = '0;
          buf_clr   = 1'b1;
          state_d   = (cfg_row_num_i == '0 || cfg_grp_num_i == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bias_vld_i) begin
          load_cur = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fire) begin
          if (!last_row) begin
            row_d = row_q + ROW_WD'(1);
          end else begin
            row_d = '0;
            if (last_grp) begin
              state_d = ST_DONE;
            end else begin
              grp_d = grp_q + GRP_WD'(1);
              if (shd_vld)       promote  = 1'b1;
              else if (bias_hs)  load_cur = 1'b1;
              else               state_d  = ST_LOAD;
            end
          end
        end
        // A beat arriving at a group end goes straight to bias_cur instead.
        if (bias_hs && !(fire && last_row)) begin
          load_shd = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      grp_q     <= '0;
      row_num_q <= '0;
      grp_num_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      grp_q     <= grp_d;
      row_num_q <= row_num_d;
      grp_num_q <= grp_num_d;
      busy_q    <= busy_d;
    end
  end

  pu_bias_shadow_buf #(
    .DATA_WD (BEAT_WD)
  ) u_shadow_buf (
    .clk        (clk),
    .rstn       (rstn),
    .clr_i      (buf_clr),
    .load_cur_i (load_cur),
    .load_shd_i (load_shd),
    .promote_i  (promote),
    .data_i     (bias_data_i),
    .cur_o      (bias_cur),
    .shd_vld_o  (shd_vld)
  );

  assign {bias_oc0_o, bias_oc1_o, bias_oc2_o, bias_oc3_o} = bias_cur;
  assign busy_o    = busy_q;
  assign done_o    = (state_q == ST_DONE);
  assign row_idx_o = row_q;
  assign grp_idx_o = grp_q;

endmodule
`default_nettype wire
